// File: rtl/frame_config_loader.sv
// rtl/frame_config_loader.sv - parses header/data words and drives per-tile FrameData and FrameStrobe
module frame_config_loader #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 2,
    parameter int NumColumns      = 4
) (
    input  logic                                  CLK,
    input  logic                                  reset,
    input  logic [FrameBitsPerRow-1:0]            in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  err,
    input  logic                                  err_clr,
    output logic [15:0]                           frames_done
);

    localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int NS = NumColumns * MaxFramesPerCol;
    localparam logic [RW-1:0] LAST_ROW = RW'(NumRows - 1);
    localparam logic [7:0] NUM_COL8 = 8'(NumColumns);
    localparam logic [7:0] NUM_FRM8 = 8'(MaxFramesPerCol);
    localparam logic [7:0] SYNC     = 8'hFA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STROBE = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [RW-1:0]                     row_cnt_q, row_cnt_d;
    logic [7:0]                        col_q, col_d;
    logic [7:0]                        frame_q, frame_d;
    logic                              bad_addr_q, bad_addr_d;
    logic [NumRows*FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
    logic [NS-1:0]                     frame_strobe_q, frame_strobe_d;
    logic                              err_q, err_d;
    logic [15:0]                       frames_done_q, frames_done_d;

    logic        accept;
    logic        err_set;
    logic [31:0] strobe_idx;

    assign in_ready    = (state_q != STROBE);
    assign busy        = (state_q != IDLE);
    assign accept      = in_valid && in_ready;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = frame_strobe_q;
    assign err         = err_q;
    assign frames_done = frames_done_q;

    // Flat strobe bit position for the latched column/frame address
    assign strobe_idx = 32'(col_q) * 32'(MaxFramesPerCol) + 32'(frame_q);

    // Next-state and datapath: header decode, row loading, strobe generation, error and frame counting
    always_comb begin
        state_d        = state_q;
        row_cnt_d      = row_cnt_q;
        col_d          = col_q;
        frame_d        = frame_q;
        bad_addr_d     = bad_addr_q;
        frame_data_d   = frame_data_q;
        frame_strobe_d = '0;
        frames_done_d  = frames_done_q;
        err_set        = 1'b0;
        err_d          = err_q & ~err_clr;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_data[31:24] == SYNC) begin
                        col_d      = in_data[23:16];
                        frame_d    = in_data[15:8];
                        row_cnt_d  = '0;
                        bad_addr_d = (in_data[23:16] >= NUM_COL8) || (in_data[15:8] >= NUM_FRM8);
                        state_d    = DATA;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    for (int r = 0; r < NumRows; r++) begin
                        if (row_cnt_q == RW'(r)) begin
                            frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = in_data;
                        end
                    end
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == LAST_ROW) begin
                        row_cnt_d = '0;
                        if (bad_addr_q) begin
                            // Out-of-range address: data still lands in the row registers, but no tile is strobed
                            err_set    = 1'b1;
                            bad_addr_d = 1'b0;
                            state_d    = IDLE;
                        end else begin
                            for (int i = 0; i < NS; i++) begin
                                frame_strobe_d[i] = (32'(i) == strobe_idx);
                            end
                            state_d = STROBE;
                        end
                    end
                end
            end
            STROBE: begin
                if (frames_done_q != 16'hFFFF) begin
                    frames_done_d = frames_done_q + 16'd1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new error overrides a simultaneous clear
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            row_cnt_q      <= '0;
            col_q          <= '0;
            frame_q        <= '0;
            bad_addr_q     <= 1'b0;
            frame_data_q   <= '0;
            frame_strobe_q <= '0;
            err_q          <= 1'b0;
            frames_done_q  <= '0;
        end else begin
            state_q        <= state_d;
            row_cnt_q      <= row_cnt_d;
            col_q          <= col_d;
            frame_q        <= frame_d;
            bad_addr_q     <= bad_addr_d;
            frame_data_q   <= frame_data_d;
            frame_strobe_q <= frame_strobe_d;
            err_q          <= err_d;
            frames_done_q  <= frames_done_d;
        end
    end

endmodule

// File: tb/tb_frame_config_loader.sv
// tb/tb_frame_config_loader.sv - randomized frame-level checks of frame_config_loader against a reference model
module tb_frame_config_loader;

    logic        CLK;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] FrameData;
    logic [79:0] FrameStrobe;
    logic        busy;
    logic        err;
    logic        err_clr;
    logic [15:0] frames_done;

    int pass_cnt = 0;
    int total    = 0;

    logic [15:0] exp_done;
    logic        exp_err;

    logic [79:0] slog[$];
    logic [63:0] dlog[$];

    frame_config_loader #(
        .FrameBitsPerRow(32),
        .MaxFramesPerCol(20),
        .NumRows(2),
        .NumColumns(4)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .FrameData(FrameData),
        .FrameStrobe(FrameStrobe),
        .busy(busy),
        .err(err),
        .err_clr(err_clr),
        .frames_done(frames_done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Record every cycle in which any strobe bit is high, with the data visible to the tiles
    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            slog.push_back(FrameStrobe);
            dlog.push_back(FrameData);
        end
    end

    function automatic logic [79:0] sbit(input int c, input int f);
        logic [79:0] v;
        v = '0;
        v[c*20+f] = 1'b1;
        return v;
    endfunction

    task automatic send(input logic [31:0] w, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge CLK);
        end
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout: in_ready=%0b required 1 for word %h", in_ready, w);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic test_reset;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", in_ready); else pass_cnt++;
        total++; if (FrameData !== 64'h0) $display("FAIL rst_framedata: got %h want 0", FrameData); else pass_cnt++;
        total++; if (FrameStrobe !== 80'h0) $display("FAIL rst_strobe: got %h want 0", FrameStrobe); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else pass_cnt++;
        total++; if (err !== 1'b0) $display("FAIL rst_err: got %0b want 0", err); else pass_cnt++;
        total++; if (frames_done !== 16'h0) $display("FAIL rst_frames_done: got %h want 0", frames_done); else pass_cnt++;
    endtask

    task automatic test_basic;
        slog.delete(); dlog.delete();
        send(32'hFA010300, 0);
        send(32'hDEADBEEF, 0);
        send(32'h12345678, 0);
        total++; if (FrameStrobe !== sbit(1, 3)) $display("FAIL basic_strobe: got %h want %h", FrameStrobe, sbit(1, 3)); else pass_cnt++;
        total++; if (in_ready !== 1'b0) $display("FAIL basic_ready_strobe: got %0b want 0", in_ready); else pass_cnt++;
        total++; if (FrameData !== {32'h12345678, 32'hDEADBEEF}) $display("FAIL basic_data: got %h want %h", FrameData, {32'h12345678, 32'hDEADBEEF}); else pass_cnt++;
        in_valid = 1'b0;
        @(negedge CLK);
        exp_done = exp_done + 16'd1;
        total++; if (FrameStrobe !== 80'h0) $display("FAIL basic_strobe_off: got %h want 0", FrameStrobe); else pass_cnt++;
        total++; if (in_ready !== 1'b1) $display("FAIL basic_ready_after: got %0b want 1", in_ready); else pass_cnt++;
        total++; if (frames_done !== exp_done) $display("FAIL basic_done: got %0d want %0d", frames_done, exp_done); else pass_cnt++;
        total++; if (slog.size() != 1) $display("FAIL basic_strobe_cycles: got %0d want 1", slog.size()); else pass_cnt++;
    endtask

    task automatic test_bad_sync;
        slog.delete(); dlog.delete();
        send(32'h11000000, 0);
        idle(2);
        total++; if (err !== 1'b1) $display("FAIL badsync_err: got %0b want 1", err); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL badsync_busy: got %0b want 0", busy); else pass_cnt++;
        total++; if (slog.size() != 0) $display("FAIL badsync_strobe: got %0d strobe cycles want 0", slog.size()); else pass_cnt++;
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        total++; if (err !== 1'b0) $display("FAIL badsync_clr: got %0b want 0", err); else pass_cnt++;
        send(32'hFA020700, 0);
        send(32'hA5A5A5A5, 0);
        send(32'h5A5A5A5A, 0);
        idle(2);
        exp_done = exp_done + 16'd1;
        total++; if (slog.size() != 1 || slog[0] !== sbit(2, 7)) $display("FAIL badsync_follow: got %0d strobes want one at bit 47", slog.size()); else pass_cnt++;
        total++; if (frames_done !== exp_done) $display("FAIL badsync_done: got %0d want %0d", frames_done, exp_done); else pass_cnt++;
    endtask

    task automatic test_bad_addr;
        slog.delete(); dlog.delete();
        send(32'hFA050000, 0);
        send(32'h01020304, 0);
        send(32'h0A0B0C0D, 0);
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL badaddr_ready: in_ready=%0b busy=%0b want 1 0", in_ready, busy); else pass_cnt++;
        in_valid = 1'b0;
        idle(2);
        total++; if (slog.size() != 0) $display("FAIL badaddr_strobe: got %0d strobe cycles want 0", slog.size()); else pass_cnt++;
        total++; if (err !== 1'b1) $display("FAIL badaddr_err: got %0b want 1", err); else pass_cnt++;
        total++; if (frames_done !== exp_done) $display("FAIL badaddr_done: got %0d want %0d", frames_done, exp_done); else pass_cnt++;
        total++; if (FrameData !== {32'h0A0B0C0D, 32'h01020304}) $display("FAIL badaddr_data: got %h want %h", FrameData, {32'h0A0B0C0D, 32'h01020304}); else pass_cnt++;
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
    endtask

    task automatic test_gaps;
        slog.delete(); dlog.delete();
        send(32'hFA031200, 0);
        send(32'hCAFEF00D, 2);
        send(32'h8BADF00D, 1);
        total++; if (FrameStrobe !== sbit(3, 18)) $display("FAIL gaps_strobe: got %h want %h", FrameStrobe, sbit(3, 18)); else pass_cnt++;
        total++; if (FrameData !== {32'h8BADF00D, 32'hCAFEF00D}) $display("FAIL gaps_data: got %h want %h", FrameData, {32'h8BADF00D, 32'hCAFEF00D}); else pass_cnt++;
        idle(2);
        exp_done = exp_done + 16'd1;
        total++; if (slog.size() != 1 || busy !== 1'b0) $display("FAIL gaps_count: strobes=%0d busy=%0b want 1 0", slog.size(), busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        slog.delete(); dlog.delete();
        send(32'hFA000400, 0);
        send(32'h77777777, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        exp_done = 16'h0;
        exp_err  = 1'b0;
        total++; if (FrameData !== 64'h0) $display("FAIL rstmid_data: got %h want 0", FrameData); else pass_cnt++;
        total++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_state: busy=%0b in_ready=%0b want 0 1", busy, in_ready); else pass_cnt++;
        @(negedge CLK);
        reset = 1'b0;
        send(32'hFA001300, 0);
        send(32'h11112222, 0);
        send(32'h33334444, 0);
        idle(2);
        exp_done = 16'd1;
        total++; if (slog.size() != 1 || slog[0] !== sbit(0, 19)) $display("FAIL rstmid_strobe: got %0d strobes want one at bit 19", slog.size()); else pass_cnt++;
        total++; if (dlog.size() == 1 && dlog[0] !== {32'h33334444, 32'h11112222}) $display("FAIL rstmid_data2: got %h want %h", dlog[0], {32'h33334444, 32'h11112222}); else pass_cnt++;
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            int          col;
            int          fr;
            bit          good;
            logic [7:0]  sy;
            logic [31:0] d0;
            logic [31:0] d1;
            int          exp_n;
            col  = $urandom_range(0, 5);
            fr   = $urandom_range(0, 22);
            good = ($urandom_range(0, 7) != 0);
            sy   = good ? 8'hFA : 8'($urandom_range(0, 255));
            if (!good && sy == 8'hFA) sy = 8'h5A;
            d0 = $urandom;
            d1 = $urandom;
            slog.delete(); dlog.delete();
            send({sy, 8'(col), 8'(fr), 8'($urandom_range(0, 255))}, $urandom_range(0, 2));
            if (good) begin
                send(d0, $urandom_range(0, 2));
                send(d1, $urandom_range(0, 2));
            end
            idle(2);
            exp_n = 0;
            if (!good || col >= 4 || fr >= 20) begin
                exp_err = 1'b1;
            end else begin
                exp_n = 1;
                if (exp_done != 16'hFFFF) exp_done = exp_done + 16'd1;
            end
            total++; if (slog.size() != exp_n) $display("FAIL rnd%0d_strobes: got %0d want %0d", k, slog.size(), exp_n); else pass_cnt++;
            if (exp_n == 1 && slog.size() == 1) begin
                total++; if (slog[0] !== sbit(col, fr)) $display("FAIL rnd%0d_bit: got %h want %h", k, slog[0], sbit(col, fr)); else pass_cnt++;
                total++; if (dlog[0] !== {d1, d0}) $display("FAIL rnd%0d_sdata: got %h want %h", k, dlog[0], {d1, d0}); else pass_cnt++;
            end
            if (good) begin
                total++; if (FrameData !== {d1, d0}) $display("FAIL rnd%0d_data: got %h want %h", k, FrameData, {d1, d0}); else pass_cnt++;
            end
            total++; if (err !== exp_err) $display("FAIL rnd%0d_err: got %0b want %0b", k, err, exp_err); else pass_cnt++;
            total++; if (frames_done !== exp_done) $display("FAIL rnd%0d_done: got %0d want %0d", k, frames_done, exp_done); else pass_cnt++;
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1;
                @(negedge CLK);
                err_clr = 1'b0;
                exp_err = 1'b0;
            end
        end
    endtask

    task automatic test_saturation;
        force dut.frames_done_q = 16'hFFFE;
        #1;
        release dut.frames_done_q;
        exp_done = 16'hFFFE;
        total++; if (frames_done !== exp_done) $display("FAIL sat_preload: got %h want %h", frames_done, exp_done); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            send(32'hFA020100, 0);
            send($urandom, 0);
            send($urandom, 0);
            idle(2);
            exp_done = 16'hFFFF;
            total++; if (frames_done !== exp_done) $display("FAIL sat_frame%0d: got %h want %h", k, frames_done, exp_done); else pass_cnt++;
        end
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        total++; if (err !== 1'b0) $display("FAIL coll_pre: got %0b want 0", err); else pass_cnt++;
        in_data  = 32'h11000000;
        in_valid = 1'b1;
        err_clr  = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        err_clr  = 1'b0;
        total++; if (err !== 1'b1) $display("FAIL coll_err: got %0b want 1", err); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL coll_busy: got %0b want 0", busy); else pass_cnt++;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'h0;
        err_clr  = 1'b0;
        exp_done = 16'h0;
        exp_err  = 1'b0;
        #1;
        test_reset;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        test_basic;
        test_bad_sync;
        test_bad_addr;
        test_gaps;
        test_reset_mid;
        test_random;
        test_saturation;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
